// File: rtl/riscv_dmem_split_sequencer_if.sv
// Data-memory bus between the access sequencer and the memory.
// master: drives the request beat; slave: returns ack and read data.
interface riscv_dmem_split_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int B = DATA_W / 8;

    logic              bus_valid;
    logic              bus_ack;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_write;
    logic              bus_sequential;
    logic [B-1:0]      bus_byte_en;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_addr,
        output bus_write,
        output bus_sequential,
        output bus_byte_en,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_addr,
        input  bus_write,
        input  bus_sequential,
        input  bus_byte_en,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/riscv_dmem_split_sequencer.sv
// Data-memory access sequencer: one load/store in, one or two aligned
// bus beats out, one merged and sign-extended completion back.
// Ports: clk, reset (sync, active-high); req_* request handshake;
// bus (master modport) for bus beats; done_* completion pulse + faults.
module riscv_dmem_split_sequencer #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    riscv_dmem_split_sequencer_if.master bus,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_rdata,
    output logic              load_misaligned,
    output logic              store_misaligned,
    output logic              size_fault
);
    localparam int B  = DATA_W / 8;
    localparam int OW = $clog2(B);
    localparam int MW = 2 * B;

    typedef enum logic [1:0] {
        IDLE,
        BEAT1,
        BEAT2,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request decode, consumed only on accept.
    logic [OW-1:0]     req_off;
    logic [3:0]        req_n;
    logic [7:0]        req_nmask;
    logic              req_mis;
    logic              req_mis_flt;
    logic              req_cross;
    logic              req_size_flt;
    logic              req_fault;
    logic [MW-1:0]     req_mask;
    logic [DATA_W-1:0] req_wrot;

    // Held access.
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              signed_q;
    logic              cross_q;
    logic [MW-1:0]     mask_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;
    logic              lmis_q;
    logic              smis_q;
    logic              sflt_q;

    logic [ADDR_W-1:0] addr_al;
    logic              fault_any;
    logic              accept;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] merged;
    logic              sign_bit;
    int                nbytes;

    always_comb begin
        req_off = req_addr[OW-1:0];
        req_n   = 4'd1 << req_size;
        unique case (req_size)
            2'd0:    req_nmask = 8'h01;
            2'd1:    req_nmask = 8'h03;
            2'd2:    req_nmask = 8'h0F;
            default: req_nmask = 8'hFF;
        endcase
        req_mis      = (4'(req_off) & (req_n - 4'd1)) != 4'd0;
        req_cross    = (int'(req_off) + int'(req_n)) > B;
        req_size_flt = (DATA_W == 32) && (req_size == 2'd3);
        req_mis_flt  = req_mis && (ALLOW_MISALIGNED == 0);
        req_fault    = req_size_flt || req_mis_flt;
        req_mask     = MW'(req_nmask) << req_off;
        // Rotate left by the byte offset: low half of {w,w} >> (W - sh).
        req_wrot = DATA_W'({req_wdata, req_wdata}
                           >> (DATA_W - 8 * int'(req_off)));
    end

    assign accept    = (state_q == IDLE) && req_valid;
    assign addr_al   = addr_q & ~ADDR_W'(B - 1);
    assign fault_any = lmis_q | smis_q | sflt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            cross_q  <= 1'b0;
            mask_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            lmis_q   <= 1'b0;
            smis_q   <= 1'b0;
            sflt_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                write_q  <= req_write;
                signed_q <= req_signed;
                cross_q  <= req_cross;
                mask_q   <= req_mask;
                wdata_q  <= req_wrot;
                lo_q     <= '0;
                hi_q     <= '0;
                sflt_q   <= req_size_flt;
                // Size fault takes precedence over alignment.
                lmis_q <= !req_size_flt && req_mis_flt && !req_write;
                smis_q <= !req_size_flt && req_mis_flt && req_write;
            end
            if (state_q == BEAT1 && bus.bus_ack && !write_q) begin
                lo_q <= bus.bus_rdata;
            end
            if (state_q == BEAT2 && bus.bus_ack && !write_q) begin
                hi_q <= bus.bus_rdata;
            end
        end
    end

    // Load merge: align the two beats, clear or sign-fill above N bytes.
    always_comb begin
        shifted  = DATA_W'({hi_q, lo_q} >> {addr_q[OW-1:0], 3'b000});
        nbytes   = 1 << size_q;
        sign_bit = 1'b0;
        for (int i = 0; i < B; i++) begin
            if (i == nbytes - 1) begin
                sign_bit = shifted[8*i+7];
            end
        end
        sign_bit = sign_bit & signed_q;
        merged   = '0;
        for (int i = 0; i < B; i++) begin
            merged[8*i +: 8] = (i < nbytes) ? shifted[8*i +: 8]
                                            : {8{sign_bit}};
        end
    end

    always_comb begin
        state_d            = state_q;
        req_ready          = 1'b0;
        bus.bus_valid      = 1'b0;
        bus.bus_addr       = addr_al;
        bus.bus_write      = write_q;
        bus.bus_sequential = 1'b0;
        bus.bus_byte_en    = '0;
        bus.bus_wdata      = wdata_q;
        done_valid         = 1'b0;
        done_rdata         = '0;
        load_misaligned    = 1'b0;
        store_misaligned   = 1'b0;
        size_fault         = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_fault ? DONE : BEAT1;
                end
            end
            BEAT1: begin
                bus.bus_valid   = 1'b1;
                bus.bus_byte_en = mask_q[B-1:0];
                if (bus.bus_ack) begin
                    state_d = cross_q ? BEAT2 : DONE;
                end
            end
            BEAT2: begin
                bus.bus_valid      = 1'b1;
                bus.bus_sequential = 1'b1;
                bus.bus_addr       = addr_al + ADDR_W'(B);
                bus.bus_byte_en    = mask_q[MW-1:B];
                if (bus.bus_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_valid       = 1'b1;
                load_misaligned  = lmis_q;
                store_misaligned = smis_q;
                size_fault       = sflt_q;
                if (!write_q && !fault_any) begin
                    done_rdata = merged;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_riscv_dmem_split_sequencer.sv
// Scoreboard bench for riscv_dmem_split_sequencer (DATA_W=32):
// expected beats/completions queued at stimulus, popped at output.
module tb_riscv_dmem_split_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic        load_misaligned;
    logic        store_misaligned;
    logic        size_fault;

    logic        nm_req_ready;
    logic        nm_done_valid;
    logic [31:0] nm_done_rdata;
    logic        nm_load_misaligned;
    logic        nm_store_misaligned;
    logic        nm_size_fault;

    riscv_dmem_split_sequencer_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();
    riscv_dmem_split_sequencer_if #(.DATA_W(32), .ADDR_W(32)) nm_bus ();

    riscv_dmem_split_sequencer #(
        .DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .bus(bus_if),
        .done_valid(done_valid), .done_rdata(done_rdata),
        .load_misaligned(load_misaligned),
        .store_misaligned(store_misaligned),
        .size_fault(size_fault)
    );

    riscv_dmem_split_sequencer #(
        .DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)
    ) dut_nm (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(nm_req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .bus(nm_bus),
        .done_valid(nm_done_valid), .done_rdata(nm_done_rdata),
        .load_misaligned(nm_load_misaligned),
        .store_misaligned(nm_store_misaligned),
        .size_fault(nm_size_fault)
    );

    assign nm_bus.bus_ack   = nm_bus.bus_valid;
    assign nm_bus.bus_rdata = 32'h0;

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic        seq;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        lm;
        logic        sm;
        logic        sf;
        int          lat;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_done_cyc = 0;
    int waited = 0;
    bit spurious = 1'b0;
    bit nm_bus_seen = 1'b0;

    function automatic logic [31:0] rotl(input logic [31:0] w,
                                         input int s);
        return (w << s) | (w >> (32 - s));
    endfunction

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be,
                             input logic wr, input logic seq,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int w);
        beat_t b;
        b.addr = a; b.be = be; b.wr = wr; b.seq = seq;
        b.wdata = wd; b.rdata = rd; b.waits = w;
        beat_q.push_back(b);
    endtask

    task automatic push_done(input logic [31:0] rd, input logic lm,
                             input logic sm, input logic sf, input int lat);
        done_t d;
        d.rdata = rd; d.lm = lm; d.sm = sm; d.sf = sf; d.lat = lat;
        done_q.push_back(d);
    endtask

    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [1:0] s, input logic sg,
                         input logic [31:0] wd);
        @(posedge clk);
        #1;
        req_addr = a; req_write = w; req_size = s;
        req_signed = sg; req_wdata = wd; req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (beat_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    // Memory responder and scoreboard monitor.
    initial begin
        beat_t eb;
        done_t ed;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (nm_bus.bus_valid === 1'b1) nm_bus_seen = 1'b1;
            if (reset !== 1'b0) begin
                bus_if.bus_ack = 1'b0;
                waited = 0;
            end else begin
                if (req_valid && req_ready) acc_cyc = cyc;
                if (bus_if.bus_valid === 1'b1) begin
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat addr=%h be=%h",
                                 bus_if.bus_addr, bus_if.bus_byte_en);
                        bus_if.bus_ack = 1'b0;
                    end else begin
                        eb = beat_q[0];
                        if (bus_if.bus_addr !== eb.addr ||
                            bus_if.bus_byte_en !== eb.be ||
                            bus_if.bus_write !== eb.wr ||
                            bus_if.bus_sequential !== eb.seq ||
                            bus_if.bus_wdata !== eb.wdata) begin
                            errors++;
                            $display({"FAIL beat got a=%h be=%h w=%b s=%b",
                                      " wd=%h want a=%h be=%h w=%b s=%b",
                                      " wd=%h"},
                                     bus_if.bus_addr, bus_if.bus_byte_en,
                                     bus_if.bus_write, bus_if.bus_sequential,
                                     bus_if.bus_wdata, eb.addr, eb.be, eb.wr,
                                     eb.seq, eb.wdata);
                        end
                        if (waited < eb.waits) begin
                            waited++;
                            bus_if.bus_ack = 1'b0;
                            bus_if.bus_rdata = $urandom;
                        end else begin
                            waited = 0;
                            bus_if.bus_ack = 1'b1;
                            bus_if.bus_rdata = eb.rdata;
                            void'(beat_q.pop_front());
                        end
                    end
                end else begin
                    bus_if.bus_ack = spurious;
                    bus_if.bus_rdata = $urandom;
                end
                if (done_valid === 1'b1) begin
                    last_done_cyc = cyc;
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done rdata=%h", done_rdata);
                    end else begin
                        ed = done_q.pop_front();
                        checks += 2;
                        if (done_rdata !== ed.rdata ||
                            load_misaligned !== ed.lm ||
                            store_misaligned !== ed.sm ||
                            size_fault !== ed.sf) begin
                            errors++;
                            $display({"FAIL done got rd=%h lm=%b sm=%b sf=%b",
                                      " want rd=%h lm=%b sm=%b sf=%b"},
                                     done_rdata, load_misaligned,
                                     store_misaligned, size_fault,
                                     ed.rdata, ed.lm, ed.sm, ed.sf);
                        end
                        if (cyc - acc_cyc !== ed.lat) begin
                            errors++;
                            $display("FAIL latency got %0d want %0d",
                                     cyc - acc_cyc, ed.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_size = '0; req_signed = 1'b0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 4;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        if (bus_if.bus_valid !== 1'b0 || bus_if.bus_byte_en !== 4'h0 ||
            bus_if.bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got v=%b be=%h a=%h want 0 0 0",
                     bus_if.bus_valid, bus_if.bus_byte_en, bus_if.bus_addr);
        end
        if (done_valid !== 1'b0 || done_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_done got v=%b rd=%h want 0 0",
                     done_valid, done_rdata);
        end
        if ({load_misaligned, store_misaligned, size_fault} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                     {load_misaligned, store_misaligned, size_fault});
        end
    endtask

    task automatic check_drain(input string name);
        bit ok;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain got beats=%0d dones=%0d want 0 0",
                     name, beat_q.size(), done_q.size());
        end
    endtask

    task automatic test_aligned_load();
        push_beat(32'h1000, 4'hF, 0, 0, 0, 32'hDEADBEEF, 0);
        push_done(32'hDEADBEEF, 0, 0, 0, 2);
        issue(32'h1000, 0, 2'd2, 0, 0);
        check_drain("aligned_load");
    endtask

    task automatic test_split_load();
        push_beat(32'h1000, 4'h8, 0, 0, 0, 32'h44332211, 0);
        push_beat(32'h1004, 4'h7, 0, 1, 0, 32'h88776655, 0);
        push_done(32'h77665544, 0, 0, 0, 3);
        issue(32'h1003, 0, 2'd2, 0, 0);
        check_drain("split_load");
    endtask

    task automatic test_half_sign();
        push_beat(32'h2000, 4'h6, 0, 0, 0, 32'h0080FF00, 0);
        push_done(32'hFFFF80FF, 0, 0, 0, 2);
        issue(32'h2001, 0, 2'd1, 1, 0);
        check_drain("lh_signed");
        push_beat(32'h2000, 4'h6, 0, 0, 0, 32'h0080FF00, 0);
        push_done(32'h000080FF, 0, 0, 0, 2);
        issue(32'h2001, 0, 2'd1, 0, 0);
        check_drain("lh_unsigned");
    endtask

    task automatic test_split_store_wait();
        push_beat(32'h3000, 4'h8, 1, 0, 32'hCD0000AB, 32'h0, 3);
        push_beat(32'h3004, 4'h1, 1, 1, 32'hCD0000AB, 32'h0, 0);
        push_done(32'h0, 0, 0, 0, 6);
        issue(32'h3003, 1, 2'd1, 0, 32'h0000ABCD);
        check_drain("sh_split_wait");
    endtask

    task automatic test_byte_access();
        logic [31:0] d;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [15:0] h;
        logic [3:0]  be;
        for (int off = 0; off < 4; off++) begin
            d  = $urandom;
            be = 4'(1 << off);
            push_beat(32'h4000, be, 0, 0, 0, d, off % 2);
            push_done({{24{d[8*off+7]}}, d[8*off +: 8]}, 0, 0, 0,
                      2 + off % 2);
            issue(32'h4000 + 32'(off), 0, 2'd0, 1, 0);
            check_drain("lb");
            d = $urandom;
            push_beat(32'h5000, be, 1, 0, rotl(d, 8 * off), 0, 0);
            push_done(32'h0, 0, 0, 0, 2);
            issue(32'h5000 + 32'(off), 1, 2'd0, 0, d);
            check_drain("sb");
        end
        lo = $urandom;
        hi = $urandom;
        h  = {hi[7:0], lo[31:24]};
        push_beat(32'h6000, 4'h8, 0, 0, 0, lo, 0);
        push_beat(32'h6004, 4'h1, 0, 1, 0, hi, 1);
        push_done({{16{h[15]}}, h}, 0, 0, 0, 4);
        issue(32'h6003, 0, 2'd1, 1, 0);
        check_drain("lh_split");
        push_beat(32'h6000, 4'hC, 0, 0, 0, lo, 0);
        push_done({16'h0, lo[31:16]}, 0, 0, 0, 2);
        issue(32'h6002, 0, 2'd1, 0, 0);
        check_drain("lhu");
    endtask

    task automatic test_faults();
        push_done(32'h0, 0, 0, 1, 1);
        issue(32'h1000, 0, 2'd3, 0, 0);
        @(negedge clk);
        checks++;
        if (nm_done_valid !== 1'b1 || nm_size_fault !== 1'b1) begin
            errors++;
            $display("FAIL nm_size_fault got v=%b sf=%b want 1 1",
                     nm_done_valid, nm_size_fault);
        end
        check_drain("size_fault");

        nm_bus_seen = 1'b0;
        push_beat(32'h1000, 4'hC, 0, 0, 0, 32'h44332211, 0);
        push_beat(32'h1004, 4'h3, 0, 1, 0, 32'h88776655, 0);
        push_done(32'h66554433, 0, 0, 0, 3);
        issue(32'h1002, 0, 2'd2, 0, 0);
        @(negedge clk);
        checks++;
        if (nm_done_valid !== 1'b1 || nm_load_misaligned !== 1'b1 ||
            nm_store_misaligned !== 1'b0 || nm_done_rdata !== 32'h0) begin
            errors++;
            $display("FAIL nm_load_mis got v=%b lm=%b sm=%b rd=%h want 1 1 0 0",
                     nm_done_valid, nm_load_misaligned,
                     nm_store_misaligned, nm_done_rdata);
        end
        check_drain("lw_1002");

        push_beat(32'h1000, 4'hE, 1, 0, 32'h22334411, 0, 0);
        push_beat(32'h1004, 4'h1, 1, 1, 32'h22334411, 0, 0);
        push_done(32'h0, 0, 0, 0, 3);
        issue(32'h1001, 1, 2'd2, 0, 32'h11223344);
        @(negedge clk);
        checks++;
        if (nm_done_valid !== 1'b1 || nm_store_misaligned !== 1'b1 ||
            nm_load_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL nm_store_mis got v=%b sm=%b lm=%b want 1 1 0",
                     nm_done_valid, nm_store_misaligned, nm_load_misaligned);
        end
        check_drain("sw_1001");
        checks++;
        if (nm_bus_seen !== 1'b0) begin
            errors++;
            $display("FAIL nm_no_bus got %b want 0", nm_bus_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom;
        r2 = $urandom;
        spurious = 1'b1;
        push_beat(32'h7000, 4'hF, 0, 0, 0, r1, 0);
        push_done(r1, 0, 0, 0, 2);
        push_beat(32'h7004, 4'h2, 0, 0, 0, r2, 0);
        push_done({24'h0, r2[15:8]}, 0, 0, 0, 2);
        issue(32'h7000, 0, 2'd2, 0, 0);
        issue(32'h7005, 0, 2'd0, 0, 0);
        checks++;
        if (acc_cyc - last_done_cyc !== 1) begin
            errors++;
            $display("FAIL b2b_gap got %0d want 1", acc_cyc - last_done_cyc);
        end
        check_drain("back_to_back");
        spurious = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        push_beat(32'h1000, 4'h8, 0, 0, 0, 32'h44332211, 0);
        push_beat(32'h1004, 4'h7, 0, 1, 0, 32'h88776655, 1000);
        issue(32'h1003, 0, 2'd2, 0, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_if.bus_valid === 1'b1 &&
                bus_if.bus_sequential === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_beat2 got 0 want 1");
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        beat_q.delete();
        waited = 0;
        @(negedge clk);
        checks += 2;
        if (bus_if.bus_valid !== 1'b0 || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out got bv=%b dv=%b want 0 0",
                     bus_if.bus_valid, done_valid);
        end
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready got %b want 1", req_ready);
        end
        repeat (6) @(negedge clk);
        push_beat(32'h1000, 4'hF, 0, 0, 0, 32'h13572468, 0);
        push_done(32'h13572468, 0, 0, 0, 2);
        issue(32'h1000, 0, 2'd2, 0, 0);
        check_drain("after_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned_load();
        test_split_load();
        test_half_sign();
        test_split_store_wait();
        test_byte_access();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
